// File: rtl/int_gen.sv
// int_gen: memory-mapped interrupt source with a programmable down-counter.
// Register window (16 bytes at BASE_ADDR):
//   0x0 ACK    write clears pending; reads {31'b0, pending}
//   0x4 CTRL   bit0 EN, bit1 MODE (0 one-shot, 1 periodic)
//   0x8 PERIOD reload value, byte-lane writable
//   0xC COUNT  current counter, read-only
// Optional build macro: INTGEN_HOLDOFF_EN adds a HOLDOFF state that keeps irq
// low for HOLDOFF_CYCLES cycles after an ack before the mode decision.
//
// state   | meaning
// IDLE    | counter stopped, no interrupt pending
// COUNT   | counter decrementing towards expiry
// PEND    | interrupt pending, irq held high until ack
// HOLDOFF | (INTGEN_HOLDOFF_EN only) post-ack quiet period
module int_gen #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
`ifdef INTGEN_HOLDOFF_EN
  , parameter int HOLDOFF_CYCLES = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

`ifdef INTGEN_HOLDOFF_EN
  typedef enum logic [1:0] {IDLE, COUNT, PEND, HOLDOFF} state_t;
  // A zero holdoff still spends one cycle in HOLDOFF so the decode stays simple.
  localparam int HLD_LOAD = (HOLDOFF_CYCLES < 1) ? 1 : HOLDOFF_CYCLES;
  localparam int HLD_W    = $clog2(HLD_LOAD + 1);
  logic [HLD_W-1:0] hold, hold_nxt;
`else
  typedef enum logic [1:0] {IDLE, COUNT, PEND} state_t;
`endif

  state_t      state, state_nxt;
  logic        en, en_nxt;
  logic        mode, mode_nxt;
  logic [31:0] period, period_nxt;
  logic [31:0] counter, counter_nxt;
  logic        pending, pending_nxt;
  logic        irq_nxt;

  logic        hit, wr, ack_wr, ctrl_wr;
  logic [1:0]  off;
  logic [31:0] peff;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr      = hit && (byteen != 4'b0000);
  assign off     = addr[3:2];
  assign ack_wr  = wr && (off == 2'd0);
  // Only byte0 of CTRL carries bits, so a CTRL write without lane 0 is ignored.
  assign ctrl_wr = wr && (off == 2'd1) && byteen[0];
  assign peff    = (period == 32'd0) ? 32'd1 : period;

  // Combinational register read, zero outside the window.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (off)
        2'd0:    rdata = {31'd0, pending};
        2'd1:    rdata = {30'd0, mode, en};
        2'd2:    rdata = period;
        default: rdata = counter;
      endcase
    end
  end

  // Next-state and next-register computation for the controller.
  always_comb begin
    state_nxt   = state;
    en_nxt      = en;
    mode_nxt    = mode;
    period_nxt  = period;
    counter_nxt = counter;
    pending_nxt = pending;
    irq_nxt     = irq;
`ifdef INTGEN_HOLDOFF_EN
    hold_nxt    = hold;
`endif

    if (wr && (off == 2'd2)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteen[i]) period_nxt[8*i +: 8] = wdata[8*i +: 8];
      end
    end

    if (ctrl_wr) begin
      en_nxt   = wdata[0];
      mode_nxt = wdata[1];
    end

    case (state)
      IDLE: begin
        if (ctrl_wr && wdata[0]) begin
          state_nxt   = COUNT;
          counter_nxt = peff;
        end
      end
      COUNT: begin
        if (counter == 32'd1) begin
          counter_nxt = 32'd0;
          pending_nxt = 1'b1;
          irq_nxt     = 1'b1;
          state_nxt   = PEND;
        end else begin
          counter_nxt = counter - 32'd1;
        end
      end
      PEND: begin
        if (ack_wr) begin
          pending_nxt = 1'b0;
          irq_nxt     = 1'b0;
`ifdef INTGEN_HOLDOFF_EN
          state_nxt   = HOLDOFF;
          hold_nxt    = HLD_W'(HLD_LOAD);
`else
          if (mode) begin
            state_nxt   = COUNT;
            counter_nxt = peff;
          end else begin
            en_nxt    = 1'b0;
            state_nxt = IDLE;
          end
`endif
        end
      end
`ifdef INTGEN_HOLDOFF_EN
      HOLDOFF: begin
        if (hold == HLD_W'(1)) begin
          if (mode) begin
            state_nxt   = COUNT;
            counter_nxt = peff;
          end else begin
            en_nxt    = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          hold_nxt = hold - HLD_W'(1);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // Disabling wins in every state; the counter value is frozen for inspection.
    if (ctrl_wr && !wdata[0]) begin
      state_nxt   = IDLE;
      pending_nxt = 1'b0;
      irq_nxt     = 1'b0;
      counter_nxt = counter;
    end
  end

  // State and register update; reset overrides any bus write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      en      <= 1'b0;
      mode    <= 1'b0;
      period  <= 32'd0;
      counter <= 32'd0;
      pending <= 1'b0;
      irq     <= 1'b0;
`ifdef INTGEN_HOLDOFF_EN
      hold    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      en      <= en_nxt;
      mode    <= mode_nxt;
      period  <= period_nxt;
      counter <= counter_nxt;
      pending <= pending_nxt;
      irq     <= irq_nxt;
`ifdef INTGEN_HOLDOFF_EN
      hold    <= hold_nxt;
`endif
    end
  end

endmodule
